imm_encoder_loader: RTL and testbench

//  Inverse of the decode-side immediate selection: packs opcode/funct/register fields and a 32-bit

---
 rtl/imm_encoder_loader_pkg.sv | 49 ++++
 rtl/imm_encoder_loader_encoder.sv | 61 ++++++
 rtl/imm_encoder_loader.sv | 167 ++++++++++++++++
 tb/tb_imm_encoder_loader.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_encoder_loader_pkg.sv
// Shared opcodes, instruction formats and FSM states for the
// immediate encoder / instruction-memory loader.
package imm_encoder_loader_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE,
        ST_ERR
    } state_e;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } fmt_e;

    function automatic fmt_e op_format(input logic [6:0] op);
        fmt_e f;
        case (op)
            OP_REG:                   f = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR: f = FMT_I;
            OP_STORE:                 f = FMT_S;
            OP_BRANCH:                f = FMT_B;
            OP_LUI, OP_AUIPC:         f = FMT_U;
            OP_JAL:                   f = FMT_J;
            default:                  f = FMT_BAD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imm_encoder_loader_encoder.sv
// Combinational RV32I instruction encoder: fields + signed immediate
// -> {word_o, range_err_o, op_err_o}. Unknown opcodes yield a NOP.
module imm_encoder_loader_encoder
    import imm_encoder_loader_pkg::*;
(
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        range_err_o,
    output logic        op_err_o
);

    logic signed [31:0] simm;

    assign simm = imm_i;

    always_comb begin
        word_o      = NOP_INSTR;
        range_err_o = 1'b0;
        op_err_o    = 1'b0;
        case (op_format(opcode_i))
            FMT_R: begin
                word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            end
            FMT_I: begin
                word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                range_err_o = (simm < -32'sd2048) || (simm > 32'sd2047);
            end
            FMT_S: begin
                word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i,
                          imm_i[4:0], opcode_i};
                range_err_o = (simm < -32'sd2048) || (simm > 32'sd2047);
            end
            FMT_B: begin
                word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                          imm_i[4:1], imm_i[11], opcode_i};
                range_err_o = (simm < -32'sd4096) || (simm > 32'sd4094)
                              || imm_i[0];
            end
            FMT_U: begin
                word_o = {imm_i[31:12], rd_i, opcode_i};
                range_err_o = (imm_i[11:0] != 12'd0);
            end
            FMT_J: begin
                word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                          rd_i, opcode_i};
                range_err_o = (simm < -32'sd1048576)
                              || (simm > 32'sd1048574) || imm_i[0];
            end
            default: begin
                op_err_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder_loader.sv
// Streams encoded RV32I words into instruction memory before the core runs.
// Ports: clock/reset(sync, low); start; in_* request handshake + fields;
// mem_* write port with mem_ready backpressure; busy/done/count; sticky errs.
module imm_encoder_loader
    import imm_encoder_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              err_range,
    output logic              err_opcode,
    output logic              err_ovf
);

    state_e            state_q, state_d;
    logic              we_q;
    logic              last_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W:0]   count_q;
    logic              err_range_q;
    logic              err_opcode_q;
    logic              err_ovf_q;

    logic [31:0]       enc_word;
    logic              enc_rerr;
    logic              enc_oerr;

    logic              in_load;
    logic              start_go;
    logic              accept;
    logic              retire;
    logic              top_addr;
    logic              ovf_pending;

    imm_encoder_loader_encoder u_enc (
        .opcode_i    (in_opcode),
        .rd_i        (in_rd),
        .rs1_i       (in_rs1),
        .rs2_i       (in_rs2),
        .funct3_i    (in_funct3),
        .funct7_i    (in_funct7),
        .imm_i       (in_imm),
        .word_o      (enc_word),
        .range_err_o (enc_rerr),
        .op_err_o    (enc_oerr)
    );

    assign in_load  = (state_q == ST_LOAD);
    assign start_go = start
                      && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign retire   = we_q && mem_ready;
    assign top_addr = (addr_q == {ADDR_W{1'b1}});

    // A non-final word parked at the top address has no successor slot,
    // so nothing more may be accepted behind it.
    assign ovf_pending = we_q && top_addr && !last_q;

    // Once the final word is held, the stream is closed until DONE.
    assign in_ready = in_load && (!we_q || mem_ready)
                      && !ovf_pending && !(we_q && last_q);
    assign accept   = in_valid && in_ready;

    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign count      = count_q;
    assign err_range  = err_range_q;
    assign err_opcode = err_opcode_q;
    assign err_ovf    = err_ovf_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_LOAD;
            ST_LOAD: begin
                if (retire && ovf_pending) begin
                    state_d = ST_ERR;
                end else if (retire && last_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: if (start) state_d = ST_LOAD;
            default: state_d = ST_ERR;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_LOAD: busy = 1'b1;
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            we_q         <= 1'b0;
            last_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            count_q      <= '0;
            err_range_q  <= 1'b0;
            err_opcode_q <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else if (start_go) begin
            we_q         <= 1'b0;
            last_q       <= 1'b0;
            addr_q       <= ADDR_W'(BASE_ADDR);
            count_q      <= '0;
            err_range_q  <= 1'b0;
            err_opcode_q <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else if (in_load) begin
            if (retire) begin
                we_q    <= 1'b0;
                count_q <= count_q + (ADDR_W + 1)'(1);
                // Address saturates at the top; no wrap into low memory.
                if (!top_addr) begin
                    addr_q <= addr_q + ADDR_W'(1);
                end
                if (ovf_pending) begin
                    err_ovf_q <= 1'b1;
                end
            end
            // A word accepted alongside a retire lands on the bumped address.
            if (accept) begin
                we_q         <= 1'b1;
                last_q       <= in_last;
                wdata_q      <= enc_word;
                err_range_q  <= err_range_q || enc_rerr;
                err_opcode_q <= err_opcode_q || enc_oerr;
            end
        end
    end

endmodule

// File: tb/tb_imm_encoder_loader.sv
// Randomized and directed bench for imm_encoder_loader with a
// format-level reference encoder and a write-log scoreboard.
module tb_imm_encoder_loader;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } req_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [6:0]  in_opcode = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_imm = '0;
    logic        mem_ready = 1'b1;

    logic        in_ready, mem_we, busy, done;
    logic        err_range, err_opcode, err_ovf;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [10:0] count;

    logic        s_in_ready, s_mem_we, s_busy, s_done;
    logic        s_err_range, s_err_opcode, s_err_ovf;
    logic [1:0]  s_mem_addr;
    logic [31:0] s_mem_wdata;
    logic [2:0]  s_count;

    imm_encoder_loader dut (
        .clock(clock), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_imm(in_imm), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .busy(busy),
        .done(done), .count(count), .err_range(err_range),
        .err_opcode(err_opcode), .err_ovf(err_ovf)
    );

    imm_encoder_loader #(.ADDR_W(2)) dut_s (
        .clock(clock), .reset(reset), .start(start2),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_last(in_last),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_imm(in_imm), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
        .mem_wdata(s_mem_wdata), .mem_ready(mem_ready), .busy(s_busy),
        .done(s_done), .count(s_count), .err_range(s_err_range),
        .err_opcode(s_err_opcode), .err_ovf(s_err_ovf)
    );

    int nvec = 0;
    int nbad = 0;
    req_t reqs[$];
    int got_addr[$];
    logic [31:0] got_data[$];
    bit timeout;

    function automatic req_t mk(input logic [6:0] op, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] imm);
        req_t r;
        r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
        r.f3 = f3; r.f7 = f7; r.imm = imm;
        return r;
    endfunction

    // 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, -1 unknown
    function automatic int fmt_of(input logic [6:0] op);
        case (op)
            7'h33: return 0;
            7'h13, 7'h03, 7'h67: return 1;
            7'h23: return 2;
            7'h63: return 3;
            7'h37, 7'h17: return 4;
            7'h6F: return 5;
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] ref_word(input req_t r);
        logic [31:0] im, op, rd, rs1, rs2, f3, f7, w;
        im = r.imm; op = 32'(r.op); rd = 32'(r.rd);
        rs1 = 32'(r.rs1); rs2 = 32'(r.rs2);
        f3 = 32'(r.f3); f7 = 32'(r.f7);
        case (fmt_of(r.op))
            0: w = f7 << 25 | rs2 << 20 | rs1 << 15 | f3 << 12 | rd << 7 | op;
            1: w = (im & 32'hFFF) << 20 | rs1 << 15 | f3 << 12 | rd << 7 | op;
            2: w = ((im >> 5) & 32'h7F) << 25 | rs2 << 20 | rs1 << 15
                   | f3 << 12 | (im & 32'h1F) << 7 | op;
            3: w = ((im >> 12) & 32'h1) << 31 | ((im >> 5) & 32'h3F) << 25
                   | rs2 << 20 | rs1 << 15 | f3 << 12
                   | ((im >> 1) & 32'hF) << 8 | ((im >> 11) & 32'h1) << 7 | op;
            4: w = (im & 32'hFFFFF000) | rd << 7 | op;
            5: w = ((im >> 20) & 32'h1) << 31 | ((im >> 1) & 32'h3FF) << 21
                   | ((im >> 11) & 32'h1) << 20 | ((im >> 12) & 32'hFF) << 12
                   | rd << 7 | op;
            default: w = 32'h0000_0013;
        endcase
        return w;
    endfunction

    function automatic bit ref_rerr(input req_t r);
        longint v;
        v = longint'($signed(r.imm));
        case (fmt_of(r.op))
            1, 2: return (v < -2048) || (v > 2047);
            3: return (v < -4096) || (v > 4094) || (r.imm[0] == 1'b1);
            4: return (r.imm & 32'hFFF) != 0;
            5: return (v < -1048576) || (v > 1048574) || (r.imm[0] == 1'b1);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] rnd_imm();
        int v;
        case ($urandom_range(0, 4))
            0: v = int'($urandom_range(0, 8191)) - 4096;
            1: v = int'($urandom_range(0, 4095)) - 2048;
            2: v = int'($urandom & 32'hFFFFF000);
            3: v = (int'($urandom_range(0, 2097151)) - 1048576) & ~1;
            default: v = int'($urandom);
        endcase
        return 32'(v);
    endfunction

    function automatic req_t rnd_req();
        logic [6:0] ops [12];
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63,
                7'h37, 7'h17, 7'h6F, 7'h7F, 7'h0F, 7'h73};
        return mk(ops[$urandom_range(0, 11)], 5'($urandom), 5'($urandom),
                  5'($urandom), 3'($urandom), 7'($urandom), rnd_imm());
    endfunction

    task automatic set_req(input req_t r);
        in_opcode = r.op; in_rd = r.rd; in_rs1 = r.rs1; in_rs2 = r.rs2;
        in_funct3 = r.f3; in_funct7 = r.f7; in_imm = r.imm;
    endtask

    task automatic pulse_start();
        in_valid = 1'b0;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    // Feeds reqs into the big instance and logs every retired write.
    task automatic drive_stream(input int rdy_pct);
        int i;
        int cyc;
        i = 0; cyc = 0; timeout = 1'b0;
        got_addr.delete(); got_data.delete();
        while (busy && cyc < 2000) begin
            mem_ready = (int'($urandom_range(0, 99)) < rdy_pct);
            if (i < reqs.size()) begin
                set_req(reqs[i]);
                in_valid = 1'b1;
                in_last = (i == reqs.size() - 1);
            end else begin
                in_valid = 1'b0;
                in_last = 1'b0;
            end
            #1;
            if (mem_we && mem_ready) begin
                got_addr.push_back(int'(mem_addr));
                got_data.push_back(mem_wdata);
            end
            if (in_valid && in_ready) i++;
            @(posedge clock); #1;
            cyc++;
        end
        in_valid = 1'b0; in_last = 1'b0; mem_ready = 1'b1;
        if (cyc >= 2000) timeout = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        nvec += 11;
        if (mem_we !== 1'b0) begin nbad++; $display("FAIL rst_we got %b want 0", mem_we); end
        if (mem_addr !== 10'd0) begin nbad++; $display("FAIL rst_addr got %h want 0", mem_addr); end
        if (mem_wdata !== 32'd0) begin nbad++; $display("FAIL rst_wdata got %h want 0", mem_wdata); end
        if (busy !== 1'b0) begin nbad++; $display("FAIL rst_busy got %b want 0", busy); end
        if (done !== 1'b0) begin nbad++; $display("FAIL rst_done got %b want 0", done); end
        if (count !== 11'd0) begin nbad++; $display("FAIL rst_count got %0d want 0", count); end
        if (err_range !== 1'b0) begin nbad++; $display("FAIL rst_erange got %b want 0", err_range); end
        if (err_opcode !== 1'b0) begin nbad++; $display("FAIL rst_eop got %b want 0", err_opcode); end
        if (err_ovf !== 1'b0) begin nbad++; $display("FAIL rst_eovf got %b want 0", err_ovf); end
        if (in_ready !== 1'b0) begin nbad++; $display("FAIL rst_ready got %b want 0", in_ready); end
        if (s_mem_we !== 1'b0) begin nbad++; $display("FAIL rst_s_we got %b want 0", s_mem_we); end
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_addi_latency();
        pulse_start();
        set_req(mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5));
        in_valid = 1'b1; in_last = 1'b1; mem_ready = 1'b1;
        #1;
        nvec += 2;
        if (busy !== 1'b1) begin nbad++; $display("FAIL addi_busy got %b want 1", busy); end
        if (in_ready !== 1'b1) begin nbad++; $display("FAIL addi_ready got %b want 1", in_ready); end
        @(posedge clock); #1;
        in_valid = 1'b0; in_last = 1'b0;
        nvec += 3;
        if (mem_we !== 1'b1) begin nbad++; $display("FAIL addi_we got %b want 1", mem_we); end
        if (mem_wdata !== 32'h00500093) begin nbad++; $display("FAIL addi_word got %h want 00500093", mem_wdata); end
        if (mem_addr !== 10'd0) begin nbad++; $display("FAIL addi_addr got %h want 0", mem_addr); end
        @(posedge clock); #1;
        nvec += 4;
        if (mem_we !== 1'b0) begin nbad++; $display("FAIL addi_we_off got %b want 0", mem_we); end
        if (done !== 1'b1) begin nbad++; $display("FAIL addi_done got %b want 1", done); end
        if (busy !== 1'b0) begin nbad++; $display("FAIL addi_busy_off got %b want 0", busy); end
        if (count !== 11'd1) begin nbad++; $display("FAIL addi_count got %0d want 1", count); end
    endtask

    task automatic test_directed_stream();
        logic [31:0] want [4];
        want = '{32'h0020A423, 32'hFE000EE3, 32'h001000EF, 32'h123452B7};
        reqs.delete();
        reqs.push_back(mk(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8));
        reqs.push_back(mk(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC));
        reqs.push_back(mk(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048));
        reqs.push_back(mk(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000));
        pulse_start();
        drive_stream(100);
        nvec += 2;
        if (timeout) begin nbad++; $display("FAIL dir_timeout got busy want done"); end
        if (got_data.size() !== 4) begin nbad++; $display("FAIL dir_nwrites got %0d want 4", got_data.size()); end
        for (int k = 0; k < 4 && k < got_data.size(); k++) begin
            nvec += 2;
            if (got_data[k] !== want[k]) begin nbad++; $display("FAIL dir_word%0d got %h want %h", k, got_data[k], want[k]); end
            if (got_addr[k] !== k) begin nbad++; $display("FAIL dir_addr%0d got %0d want %0d", k, got_addr[k], k); end
        end
        nvec += 5;
        if (done !== 1'b1) begin nbad++; $display("FAIL dir_done got %b want 1", done); end
        if (count !== 11'd4) begin nbad++; $display("FAIL dir_count got %0d want 4", count); end
        if (err_range !== 1'b0) begin nbad++; $display("FAIL dir_erange got %b want 0", err_range); end
        if (err_opcode !== 1'b0) begin nbad++; $display("FAIL dir_eop got %b want 0", err_opcode); end
        if (err_ovf !== 1'b0) begin nbad++; $display("FAIL dir_eovf got %b want 0", err_ovf); end
    endtask

    task automatic test_errors();
        reqs.delete();
        reqs.push_back(mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048));
        pulse_start();
        drive_stream(100);
        nvec += 4;
        if (timeout || got_data.size() !== 1) begin nbad++; $display("FAIL rng_nwrites got %0d want 1", got_data.size()); end
        if (got_data.size() > 0 && got_data[0] !== 32'h80000093) begin nbad++; $display("FAIL rng_word got %h want 80000093", got_data[0]); end
        if (err_range !== 1'b1) begin nbad++; $display("FAIL rng_flag got %b want 1", err_range); end
        if (err_opcode !== 1'b0) begin nbad++; $display("FAIL rng_eop got %b want 0", err_opcode); end
        reqs.delete();
        reqs.push_back(mk(7'h7F, 5'd3, 5'd4, 5'd5, 3'd1, 7'd9, 32'd0));
        pulse_start();
        nvec += 1;
        if (err_range !== 1'b0) begin nbad++; $display("FAIL start_clr_erange got %b want 0", err_range); end
        drive_stream(100);
        nvec += 4;
        if (timeout || got_data.size() !== 1) begin nbad++; $display("FAIL bad_nwrites got %0d want 1", got_data.size()); end
        if (got_data.size() > 0 && got_data[0] !== 32'h00000013) begin nbad++; $display("FAIL bad_word got %h want 00000013", got_data[0]); end
        if (err_opcode !== 1'b1) begin nbad++; $display("FAIL bad_flag got %b want 1", err_opcode); end
        if (err_range !== 1'b0) begin nbad++; $display("FAIL bad_erange got %b want 0", err_range); end
    endtask

    task automatic test_backpressure();
        req_t a, b;
        a = mk(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        b = mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        pulse_start();
        set_req(a); in_valid = 1'b1; in_last = 1'b0; mem_ready = 1'b0;
        @(posedge clock); #1;
        set_req(b);
        for (int k = 0; k < 3; k++) begin
            #1;
            nvec += 4;
            if (mem_we !== 1'b1) begin nbad++; $display("FAIL bp_we%0d got %b want 1", k, mem_we); end
            if (mem_wdata !== 32'h0020A423) begin nbad++; $display("FAIL bp_hold%0d got %h want 0020a423", k, mem_wdata); end
            if (mem_addr !== 10'd0) begin nbad++; $display("FAIL bp_addr%0d got %h want 0", k, mem_addr); end
            if (in_ready !== 1'b0) begin nbad++; $display("FAIL bp_ready%0d got %b want 0", k, in_ready); end
            @(posedge clock); #1;
        end
        mem_ready = 1'b1; in_last = 1'b1;
        #1;
        nvec += 1;
        if (in_ready !== 1'b1) begin nbad++; $display("FAIL bp_release got %b want 1", in_ready); end
        @(posedge clock); #1;
        in_valid = 1'b0; in_last = 1'b0;
        nvec += 3;
        if (mem_we !== 1'b1) begin nbad++; $display("FAIL bp_we_b got %b want 1", mem_we); end
        if (mem_wdata !== 32'h00500093) begin nbad++; $display("FAIL bp_word_b got %h want 00500093", mem_wdata); end
        if (mem_addr !== 10'd1) begin nbad++; $display("FAIL bp_addr_b got %h want 1", mem_addr); end
        @(posedge clock); #1;
        nvec += 2;
        if (done !== 1'b1) begin nbad++; $display("FAIL bp_done got %b want 1", done); end
        if (count !== 11'd2) begin nbad++; $display("FAIL bp_count got %0d want 2", count); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            int n;
            bit er, eo;
            n = int'($urandom_range(3, 14));
            er = 1'b0; eo = 1'b0;
            reqs.delete();
            for (int k = 0; k < n; k++) begin
                reqs.push_back(rnd_req());
                er |= ref_rerr(reqs[k]);
                eo |= (fmt_of(reqs[k].op) < 0);
            end
            pulse_start();
            drive_stream(int'($urandom_range(30, 100)));
            nvec += 2;
            if (timeout) begin nbad++; $display("FAIL rnd%0d_timeout got busy want done", t); end
            if (got_data.size() !== n) begin nbad++; $display("FAIL rnd%0d_nwrites got %0d want %0d", t, got_data.size(), n); end
            for (int k = 0; k < n && k < got_data.size(); k++) begin
                nvec += 2;
                if (got_data[k] !== ref_word(reqs[k])) begin nbad++; $display("FAIL rnd%0d_word%0d got %h want %h", t, k, got_data[k], ref_word(reqs[k])); end
                if (got_addr[k] !== k) begin nbad++; $display("FAIL rnd%0d_addr%0d got %0d want %0d", t, k, got_addr[k], k); end
            end
            nvec += 5;
            if (done !== 1'b1) begin nbad++; $display("FAIL rnd%0d_done got %b want 1", t, done); end
            if (int'(count) !== n) begin nbad++; $display("FAIL rnd%0d_count got %0d want %0d", t, count, n); end
            if (err_range !== er) begin nbad++; $display("FAIL rnd%0d_erange got %b want %b", t, err_range, er); end
            if (err_opcode !== eo) begin nbad++; $display("FAIL rnd%0d_eop got %b want %b", t, err_opcode, eo); end
            if (err_ovf !== 1'b0) begin nbad++; $display("FAIL rnd%0d_eovf got %b want 0", t, err_ovf); end
        end
    endtask

    // 4-word memory: a last word at the top is legal, a fifth is not.
    task automatic test_overflow();
        for (int sc = 0; sc < 2; sc++) begin
            int n, i, cyc, nret;
            n = (sc == 0) ? 4 : 5;
            i = 0; cyc = 0; nret = 0;
            in_valid = 1'b0;
            start2 = 1'b1;
            @(posedge clock); #1;
            start2 = 1'b0;
            while (s_busy && cyc < 100) begin
                mem_ready = 1'b1;
                set_req(mk(7'h13, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i)));
                in_valid = (i < n);
                in_last = (i == n - 1);
                #1;
                if (s_mem_we && mem_ready) begin
                    nvec++;
                    if (int'(s_mem_addr) !== nret) begin nbad++; $display("FAIL ovf%0d_addr got %0d want %0d", sc, s_mem_addr, nret); end
                    nret++;
                end
                if (in_valid && s_in_ready) i++;
                @(posedge clock); #1;
                cyc++;
            end
            in_valid = 1'b0; in_last = 1'b0;
            nvec += 3;
            if (cyc >= 100) begin nbad++; $display("FAIL ovf%0d_timeout got busy want idle", sc); end
            if (i !== 4) begin nbad++; $display("FAIL ovf%0d_accepts got %0d want 4", sc, i); end
            if (s_count !== 3'd4) begin nbad++; $display("FAIL ovf%0d_count got %0d want 4", sc, s_count); end
            if (sc == 0) begin
                nvec += 2;
                if (s_done !== 1'b1) begin nbad++; $display("FAIL top_last_done got %b want 1", s_done); end
                if (s_err_ovf !== 1'b0) begin nbad++; $display("FAIL top_last_eovf got %b want 0", s_err_ovf); end
            end else begin
                nvec += 3;
                if (s_err_ovf !== 1'b1) begin nbad++; $display("FAIL ovf_flag got %b want 1", s_err_ovf); end
                if (s_done !== 1'b0) begin nbad++; $display("FAIL ovf_done got %b want 0", s_done); end
                if (s_in_ready !== 1'b0) begin nbad++; $display("FAIL ovf_ready got %b want 0", s_in_ready); end
            end
        end
        start2 = 1'b1;
        @(posedge clock); #1;
        start2 = 1'b0;
        @(posedge clock); #1;
        nvec += 2;
        if (s_busy !== 1'b0) begin nbad++; $display("FAIL err_ignores_start got %b want 0", s_busy); end
        if (s_err_ovf !== 1'b1) begin nbad++; $display("FAIL err_sticky got %b want 1", s_err_ovf); end
    endtask

    task automatic test_reset_midstream();
        pulse_start();
        set_req(mk(7'h13, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd100));
        in_valid = 1'b1; in_last = 1'b0; mem_ready = 1'b0;
        @(posedge clock); #1;
        in_valid = 1'b0;
        nvec += 1;
        if (mem_we !== 1'b1) begin nbad++; $display("FAIL mid_pending got %b want 1", mem_we); end
        reset = 1'b0;
        @(posedge clock); #1;
        nvec += 8;
        if (mem_we !== 1'b0) begin nbad++; $display("FAIL mid_we got %b want 0", mem_we); end
        if (mem_addr !== 10'd0) begin nbad++; $display("FAIL mid_addr got %h want 0", mem_addr); end
        if (mem_wdata !== 32'd0) begin nbad++; $display("FAIL mid_wdata got %h want 0", mem_wdata); end
        if (busy !== 1'b0) begin nbad++; $display("FAIL mid_busy got %b want 0", busy); end
        if (count !== 11'd0) begin nbad++; $display("FAIL mid_count got %0d want 0", count); end
        if (in_ready !== 1'b0) begin nbad++; $display("FAIL mid_ready got %b want 0", in_ready); end
        if (s_err_ovf !== 1'b0) begin nbad++; $display("FAIL mid_s_eovf got %b want 0", s_err_ovf); end
        if (s_count !== 3'd0) begin nbad++; $display("FAIL mid_s_count got %0d want 0", s_count); end
        reset = 1'b1; mem_ready = 1'b1;
        @(posedge clock); #1;
        reqs.delete();
        reqs.push_back(mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5));
        pulse_start();
        drive_stream(100);
        nvec += 3;
        if (timeout || got_data.size() !== 1) begin nbad++; $display("FAIL restart_nwrites got %0d want 1", got_data.size()); end
        if (got_addr.size() > 0 && got_addr[0] !== 0) begin nbad++; $display("FAIL restart_addr got %0d want 0", got_addr[0]); end
        if (got_data.size() > 0 && got_data[0] !== 32'h00500093) begin nbad++; $display("FAIL restart_word got %h want 00500093", got_data[0]); end
    endtask

    initial begin
        test_reset();
        test_addi_latency();
        test_directed_stream();
        test_errors();
        test_backpressure();
        test_random();
        test_overflow();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
